// File: rtl/dmem_if.sv
// dmem_if: CPU data-memory port between the MEM stage (master) and the memory
// responder (slave).
//   DMEM_address : byte address, master -> slave
//   write_data   : store data, master -> slave
//   DMEM_WRITE   : one-cycle store strobe, master -> slave
//   read_data    : combinational load data, slave -> master
interface dmem_if;
  logic [31:0] DMEM_address;
  logic [31:0] write_data;
  logic        DMEM_WRITE;
  logic [31:0] read_data;

  modport master (output DMEM_address, output write_data, output DMEM_WRITE,
                  input  read_data);
  modport slave  (input  DMEM_address, input  write_data, input  DMEM_WRITE,
                  output read_data);
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: slave end of the CPU DMEM port. Holds a word RAM and a small
// MMIO window: free-running cycle counter, compare timer, GPIO and a sticky
// error status. Reads are combinational. Writes and all peripheral state
// update on the rising clock edge.
//   clock     : system clock, rising edge
//   reset     : asynchronous, active-low
//   bus       : dmem_if slave (DMEM_address, write_data, DMEM_WRITE, read_data)
//   gpio_in   : asynchronous external inputs, synchronised internally
//   gpio_out  : registered GPIO outputs
//   timer_irq : registered timer compare flag
module dmem_responder #(
  parameter int ADDR_W = 10,
  parameter int GPIO_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  dmem_if.slave             bus,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              timer_irq
);

  localparam logic [7:0] OFF_CYCLE  = 8'h00;
  localparam logic [7:0] OFF_TCNT   = 8'h04;
  localparam logic [7:0] OFF_TCMP   = 8'h08;
  localparam logic [7:0] OFF_TCTRL  = 8'h0C;
  localparam logic [7:0] OFF_GPOUT  = 8'h10;
  localparam logic [7:0] OFF_GPIN   = 8'h14;
  localparam logic [7:0] OFF_STATUS = 8'h18;

  logic [31:0]       a;
  logic [31:0]       wdata;
  logic              is_ram;
  logic              is_mmio;
  logic [7:0]        off;
  logic [ADDR_W-1:0] idx;

  assign a       = bus.DMEM_address;
  assign wdata   = bus.write_data;
  assign is_ram  = (a[31:16] == 16'h0000);
  assign is_mmio = (a[31:16] == 16'hFFFF);
  assign off     = a[7:0];
  // Bits above the word index (up to bit 15) alias into the RAM.
  assign idx     = a[ADDR_W+1:2];

  // Byte-lane and alias bits are intentionally ignored by the decode.
  logic unused_bits;
  assign unused_bits = ^{a[15:8], a[1:0]};

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  logic [31:0]       cycle_cnt;
  logic [31:0]       tcnt;
  logic [31:0]       tcmp;
  logic              en;
  logic              reload;
  logic              err;
  logic [GPIO_W-1:0] sync_p0;
  logic [GPIO_W-1:0] sync_p1;

  logic mmio_we;
  logic wr_tcnt;
  logic wr_tcmp;
  logic wr_tctrl;
  logic wr_gpout;
  logic wr_status;
  logic err_set;
  logic hit;

  assign mmio_we   = bus.DMEM_WRITE & is_mmio;
  assign wr_tcnt   = mmio_we & (off == OFF_TCNT);
  assign wr_tcmp   = mmio_we & (off == OFF_TCMP);
  assign wr_tctrl  = mmio_we & (off == OFF_TCTRL);
  assign wr_gpout  = mmio_we & (off == OFF_GPOUT);
  assign wr_status = mmio_we & (off == OFF_STATUS);
  // Only stores outside both regions are errors; unmapped MMIO offsets are not.
  assign err_set   = bus.DMEM_WRITE & ~is_ram & ~is_mmio;
  // Compare uses the pre-edge TCNT and EN, so a same-cycle TCNT or TCTRL
  // write cannot mask a match.
  assign hit       = en & (tcnt == tcmp);

  // RAM: no reset on contents; stores are blocked while reset is held.
  always_ff @(posedge clock) begin
    if (reset && bus.DMEM_WRITE && is_ram) begin
      mem[idx] <= wdata;
    end
  end

  // Peripheral state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycle_cnt <= '0;
      tcnt      <= '0;
      tcmp      <= '0;
      en        <= 1'b0;
      reload    <= 1'b0;
      timer_irq <= 1'b0;
      err       <= 1'b0;
      gpio_out  <= '0;
      sync_p0   <= '0;
      sync_p1   <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;

      sync_p0 <= gpio_in;
      sync_p1 <= sync_p0;

      // A CPU load of TCNT wins over both increment and reload.
      if (wr_tcnt) begin
        tcnt <= wdata;
      end else if (en) begin
        tcnt <= (hit && reload) ? 32'd0 : tcnt + 32'd1;
      end

      if (wr_tcmp) begin
        tcmp <= wdata;
      end

      if (wr_tctrl) begin
        en     <= wdata[0];
        reload <= wdata[2];
      end

      // Set beats write-1-to-clear.
      if (hit) begin
        timer_irq <= 1'b1;
      end else if (wr_tctrl && wdata[1]) begin
        timer_irq <= 1'b0;
      end

      if (wr_gpout) begin
        gpio_out <= wdata[GPIO_W-1:0];
      end

      if (err_set) begin
        err <= 1'b1;
      end else if (wr_status && wdata[0]) begin
        err <= 1'b0;
      end
    end
  end

  // Combinational read mux: returns pre-edge register values.
  logic [31:0] rd_data;

  always_comb begin
    rd_data = '0;
    if (is_ram) begin
      rd_data = mem[idx];
    end else if (is_mmio) begin
      case (off)
        OFF_CYCLE:  rd_data = cycle_cnt;
        OFF_TCNT:   rd_data = tcnt;
        OFF_TCMP:   rd_data = tcmp;
        OFF_TCTRL:  rd_data = {29'd0, reload, timer_irq, en};
        OFF_GPOUT:  rd_data[GPIO_W-1:0] = gpio_out;
        OFF_GPIN:   rd_data[GPIO_W-1:0] = sync_p1;
        OFF_STATUS: rd_data = {31'd0, err};
        default:    rd_data = '0;
      endcase
    end
  end

  assign bus.read_data = rd_data;

endmodule
